led_seq_ctrl: RTL and testbench

Sequencer that owns the `led_control` select and `score` inputs of the LED output mux. It keeps a 7-bit saturating score from hit pulses. On each `start` it runs a timed display sequence (show score, then flash) and returns to the idle pattern. It sits between the game logic and the LED mux; all outputs are registered and drive the mux directly.

---
 rtl/led_seq_ctrl_if.sv | 25 ++
 rtl/led_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_led_seq_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/led_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : led_seq_ctrl_if
// Purpose  : Game-logic side bundle of the LED sequencer (requests, score, mux).
// Revision : 1.0 - initial release
// ============================================================================
interface led_seq_ctrl_if;
    logic       start;
    logic       hit;
    logic       score_clr;
    logic [6:0] score;
    logic [1:0] led_control;
    logic       busy;

    modport master (
        output start, hit, score_clr,
        input  score, led_control, busy
    );

    modport slave (
        input  start, hit, score_clr,
        output score, led_control, busy
    );
endinterface
`default_nettype wire

// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_seq_ctrl
// Purpose  : Saturating score keeper and timed LED display sequencer
//            (show score, then flash). Flash phase built only when the
//            LED_SEQ_FLASH_EN macro is defined.
// Revision : 1.0 - initial release
// ============================================================================
module led_seq_ctrl #(
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned HOLD_TICKS  = 4,
    parameter int unsigned FLASH_COUNT = 3
) (
    input  logic          clk,
    input  logic          reset,
    led_seq_ctrl_if.slave bus
);

    localparam int unsigned   c_PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned   c_HOLD_W    = $clog2(HOLD_TICKS + 1);
    localparam logic [c_PRESC_W-1:0] c_TICK_LAST = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST = c_HOLD_W'(HOLD_TICKS - 1);
    localparam logic [6:0]    c_SCORE_MAX = 7'd127;

    generate
        if (TICK_DIV < 2 || HOLD_TICKS < 1 || FLASH_COUNT < 1) begin : g_bad_params
            $error("led_seq_ctrl: illegal parameter value");
        end
    endgenerate

    // State codes double as the mux select, so led_control is the state register.
    typedef enum logic [1:0] {
        S_IDLE      = 2'b11,
        S_SHOW      = 2'b01
`ifdef LED_SEQ_FLASH_EN
        ,
        S_FLASH_ON  = 2'b10,
        S_FLASH_OFF = 2'b00
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [c_PRESC_W-1:0]  presc_q, presc_d;
    logic [c_HOLD_W-1:0]   hold_q,  hold_d;
    logic [6:0]            score_q, score_d;
    logic                  busy_q;
    logic                  w_tick;

`ifdef LED_SEQ_FLASH_EN
    localparam int unsigned          c_FLASH_W    = $clog2(FLASH_COUNT + 1);
    localparam logic [c_FLASH_W-1:0] c_FLASH_LAST = c_FLASH_W'(FLASH_COUNT - 1);
    logic [c_FLASH_W-1:0]  flash_q, flash_d;
`endif

    assign w_tick = (presc_q == c_TICK_LAST);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
`ifdef LED_SEQ_FLASH_EN
        flash_d = flash_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                if (w_tick) begin
                    if (hold_q == c_HOLD_LAST) begin
                        hold_d  = '0;
`ifdef LED_SEQ_FLASH_EN
                        state_d = S_FLASH_ON;
`else
                        state_d = S_IDLE;
`endif
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
`ifdef LED_SEQ_FLASH_EN
            S_FLASH_ON: begin
                if (w_tick) begin
                    state_d = S_FLASH_OFF;
                end
            end
            S_FLASH_OFF: begin
                if (w_tick) begin
                    if (flash_q == c_FLASH_LAST) begin
                        flash_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        flash_d = flash_q + 1'b1;
                        state_d = S_FLASH_ON;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Restarting on every transition keeps each state an exact tick multiple.
        if (state_q == S_IDLE || state_d != state_q || w_tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_comb begin
        score_d = score_q;
        if (bus.score_clr) begin
            score_d = '0;
        end else if (bus.hit && score_q != c_SCORE_MAX) begin
            score_d = score_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            hold_q  <= '0;
            score_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            hold_q  <= hold_d;
            score_q <= score_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

`ifdef LED_SEQ_FLASH_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flash_q <= '0;
        end else begin
            flash_q <= flash_d;
        end
    end
`endif

    assign bus.score       = score_q;
    assign bus.led_control = state_q;
    assign bus.busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_seq_ctrl
// Purpose  : Self-checking bench for led_seq_ctrl: vector table, directed
//            corner sequences and random traffic against a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_seq_ctrl;

    localparam int TD   = 4;
    localparam int HOLD = 2;
    localparam int FC   = 2;
`ifdef LED_SEQ_FLASH_EN
    localparam int FLASH_EN = 1;
`else
    localparam int FLASH_EN = 0;
`endif
    localparam int SHOW_LEN = HOLD * TD;
    localparam int TOTAL    = (HOLD + ((FLASH_EN != 0) ? 2 * FC : 0)) * TD;

    logic clk = 1'b0;
    logic reset;

    led_seq_ctrl_if bus ();

    led_seq_ctrl #(
        .TICK_DIV    (TD),
        .HOLD_TICKS  (HOLD),
        .FLASH_COUNT (FC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: cycles elapsed since the accepting start edge (-1 = idle), plus score.
    int seq_off = -1;
    int score_m = 0;

    typedef struct {
        logic h;
        logic c;
        int   exp_score;
    } vec_t;
    vec_t vecs[8];

    function automatic int exp_led(input int off);
        int half;
        if (off < 0)        return 3;
        if (off < SHOW_LEN) return 1;
        half = (off - SHOW_LEN) / TD;
        return (half % 2 == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " led_control"}, int'(bus.led_control), exp_led(seq_off));
        chk({tag, " busy"},        int'(bus.busy),        (seq_off >= 0) ? 1 : 0);
        chk({tag, " score"},       int'(bus.score),       score_m);
    endtask

    task automatic model_edge(input logic st, input logic h, input logic c);
        bit idle_before;
        idle_before = (seq_off < 0);
        if (seq_off >= 0) begin
            seq_off++;
            if (seq_off >= TOTAL) seq_off = -1;
        end
        if (idle_before && st) seq_off = 0;
        if (c)      score_m = 0;
        else if (h) score_m = (score_m < 127) ? score_m + 1 : 127;
    endtask

    task automatic cycle(input logic st, input logic h, input logic c, input string tag);
        bus.start     = st;
        bus.hit       = h;
        bus.score_clr = c;
        @(posedge clk);
        model_edge(st, h, c);
        #1;
        check_model(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt;
        logic st;

        vecs[0] = '{1'b1, 1'b0, 1};
        vecs[1] = '{1'b1, 1'b0, 2};
        vecs[2] = '{1'b0, 1'b0, 2};
        vecs[3] = '{1'b1, 1'b0, 3};
        vecs[4] = '{1'b1, 1'b1, 0};
        vecs[5] = '{1'b0, 1'b1, 0};
        vecs[6] = '{1'b1, 1'b0, 1};
        vecs[7] = '{1'b0, 1'b0, 1};

        bus.start     = 1'b0;
        bus.hit       = 1'b0;
        bus.score_clr = 1'b0;
        reset         = 1'b1;
        #1;
        check_model("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, "idle");

        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, vecs[i].h, vecs[i].c, "vec");
            chk($sformatf("vec%0d score", i), int'(bus.score), vecs[i].exp_score);
            chk($sformatf("vec%0d led_control", i), int'(bus.led_control), 3);
        end

        // Single start pulse: full sequence and exact busy length.
        busy_cnt = 0;
        cycle(1'b1, 1'b0, 1'b0, "seq");
        busy_cnt += int'(bus.busy);
        for (int i = 0; i < TOTAL + 4; i++) begin
            cycle(1'b0, 1'b0, 1'b0, "seq");
            busy_cnt += int'(bus.busy);
        end
        chk("seq busy_len", busy_cnt, TOTAL);

        // Saturation and clear priority.
        cycle(1'b0, 1'b0, 1'b1, "sat");
        for (int i = 0; i < 130; i++) cycle(1'b0, 1'b1, 1'b0, "sat");
        chk("sat score127", int'(bus.score), 127);
        cycle(1'b0, 1'b1, 1'b0, "sat");
        chk("sat hold127", int'(bus.score), 127);
        cycle(1'b0, 1'b1, 1'b1, "clrwin");
        chk("clrwin score", int'(bus.score), 0);

        // Starts while busy are dropped.
        busy_cnt = 0;
        cycle(1'b1, 1'b0, 1'b0, "repulse");
        busy_cnt += int'(bus.busy);
        for (int i = 1; i < TOTAL + 4; i++) begin
            st = (i == 3) || (FLASH_EN != 0 && i == SHOW_LEN + 1);
            cycle(st, 1'b0, 1'b0, "repulse");
            busy_cnt += int'(bus.busy);
        end
        chk("repulse busy_len", busy_cnt, TOTAL);

        // Async reset in the middle of SHOW.
        cycle(1'b0, 1'b0, 1'b1, "prerst");
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0, "prerst");
        chk("prerst score9", int'(bus.score), 9);
        cycle(1'b1, 1'b0, 1'b0, "prerst");
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, "prerst");
        #2;
        reset = 1'b1;
        #1;
        seq_off = -1;
        score_m = 0;
        chk("asyncrst led_control", int'(bus.led_control), 3);
        chk("asyncrst score", int'(bus.score), 0);
        chk("asyncrst busy", int'(bus.busy), 0);
        @(negedge clk);
        reset = 1'b0;

        busy_cnt = 0;
        cycle(1'b1, 1'b0, 1'b0, "postrst");
        busy_cnt += int'(bus.busy);
        for (int i = 0; i < TOTAL + 4; i++) begin
            cycle(1'b0, 1'b0, 1'b0, "postrst");
            busy_cnt += int'(bus.busy);
        end
        chk("postrst busy_len", busy_cnt, TOTAL);

        // Held start re-triggers right after return to idle.
        for (int i = 0; i < 2 * TOTAL + 3; i++) cycle(1'b1, 1'b0, 1'b0, "held");
        cycle(1'b0, 1'b0, 1'b0, "held");

        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 31) == 0),
                  "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
